// File: rtl/gate_test_sequencer.sv
// Sweeps every input vector of a small combinational gate, compares the gate output with an
// expected truth table and reports the error count and the first failing vector.
module gate_test_sequencer #(
    parameter int NUM_IN = 2,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**NUM_IN-1:0] exp_table,
    input  logic                 y_in,
    output logic [NUM_IN-1:0]    vec_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_IN:0]      err_count,
    output logic [NUM_IN-1:0]    first_fail,
    output logic                 fail_valid
);

    localparam int unsigned NumVec = 2 ** NUM_IN;
    localparam logic [NUM_IN-1:0] LastVec = NUM_IN'(NumVec - 1);
    localparam logic [7:0] SettleLast = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } state_t;

    state_t     state;
    logic [7:0] settle_cnt;
    logic       mismatch;

    // Only meaningful in StSample; every output below is registered, so y_in never reaches a port.
    assign mismatch = (y_in != exp_table[vec_out]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            vec_out    <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            first_fail <= '0;
            fail_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state      <= StSettle;
                        vec_out    <= '0;
                        settle_cnt <= '0;
                        err_count  <= '0;
                        first_fail <= '0;
                        fail_valid <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                    end
                end
                StSettle: begin
                    settle_cnt <= settle_cnt + 8'd1;
                    if (settle_cnt == SettleLast) begin
                        state <= StSample;
                    end
                end
                StSample: begin
                    if (mismatch) begin
                        err_count <= err_count + (NUM_IN + 1)'(1);
                        if (!fail_valid) begin
                            first_fail <= vec_out;
                            fail_valid <= 1'b1;
                        end
                    end
                    if (vec_out != LastVec) begin
                        vec_out    <= vec_out + NUM_IN'(1);
                        settle_cnt <= '0;
                        state      <= StSettle;
                    end else begin
                        // Last vector: stop on it rather than wrapping back to 0.
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= !mismatch && (err_count == '0);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench: a table of gate/truth-table sweeps on a 2-input sequencer plus hand-written
// sequences for held start, mid-sweep reset and a 3-input, SETTLE=3 instance.
module tb_gate_test_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] exp_table;
    logic       y_in;
    logic [1:0] vec_out;
    logic       busy, done, pass, fail_valid;
    logic [2:0] err_count;
    logic [1:0] first_fail;

    logic       start3;
    logic [7:0] exp_table3;
    logic       y_in3;
    logic [2:0] vec_out3;
    logic       busy3, done3, pass3, fail_valid3;
    logic [3:0] err_count3;
    logic [2:0] first_fail3;

    // Gate model: 0 AND, 1 stuck-at-0, 2 stuck-at-1, 3 XOR (vec bit 1 = a, bit 0 = b)
    logic [1:0] mode;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    always_comb begin
        y_in = 1'b0;
        case (mode)
            2'd0: y_in = vec_out[1] & vec_out[0];
            2'd1: y_in = 1'b0;
            2'd2: y_in = 1'b1;
            default: y_in = vec_out[1] ^ vec_out[0];
        endcase
    end

    assign y_in3 = &vec_out3;

    gate_test_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .exp_table  (exp_table),
        .y_in       (y_in),
        .vec_out    (vec_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .first_fail (first_fail),
        .fail_valid (fail_valid)
    );

    gate_test_sequencer #(
        .NUM_IN (3),
        .SETTLE (3)
    ) dut3 (
        .clk        (clk),
        .rst        (rst),
        .start      (start3),
        .exp_table  (exp_table3),
        .y_in       (y_in3),
        .vec_out    (vec_out3),
        .busy       (busy3),
        .done       (done3),
        .pass       (pass3),
        .err_count  (err_count3),
        .first_fail (first_fail3),
        .fail_valid (fail_valid3)
    );

    typedef struct {
        logic [1:0] mode;
        logic [3:0] tbl;
        int         err;
        int         ff;
        int         fv;
        int         pss;
    } vec_t;

    vec_t tv[7];

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges from the one that samples start until done is seen, checking vec_out on the way.
    task automatic run_sweep(input string tag, input logic [3:0] tbl, input logic hold);
        int lat;
        int seq_bad;
        seq_bad   = 0;
        exp_table = tbl;
        start     = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            if (!busy || vec_out != 2'((lat - 1) / 2)) seq_bad++;
            tick();
            lat++;
        end
        check({tag, " vec sequence"}, seq_bad, 0);
        check({tag, " done latency"}, lat, 9);
        check({tag, " busy at done"}, int'(busy), 0);
        check({tag, " vec held at 3"}, int'(vec_out), 3);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " done"}, int'(done), 0);
        check({tag, " pass"}, int'(pass), 0);
        check({tag, " err_count"}, int'(err_count), 0);
        check({tag, " first_fail"}, int'(first_fail), 0);
        check({tag, " fail_valid"}, int'(fail_valid), 0);
        check({tag, " vec_out"}, int'(vec_out), 0);
    endtask

    initial begin
        int lat;
        int seq_bad;

        tv[0] = '{mode: 2'd0, tbl: 4'b1000, err: 0, ff: 0, fv: 0, pss: 1};
        tv[1] = '{mode: 2'd1, tbl: 4'b1000, err: 1, ff: 3, fv: 1, pss: 0};
        tv[2] = '{mode: 2'd0, tbl: 4'b1110, err: 2, ff: 1, fv: 1, pss: 0};
        tv[3] = '{mode: 2'd2, tbl: 4'b1000, err: 3, ff: 0, fv: 1, pss: 0};
        tv[4] = '{mode: 2'd3, tbl: 4'b0110, err: 0, ff: 0, fv: 0, pss: 1};
        tv[5] = '{mode: 2'd2, tbl: 4'b1111, err: 0, ff: 0, fv: 0, pss: 1};
        tv[6] = '{mode: 2'd1, tbl: 4'b1111, err: 4, ff: 0, fv: 1, pss: 0};

        rst        = 1'b1;
        start      = 1'b0;
        start3     = 1'b0;
        exp_table  = 4'b0000;
        exp_table3 = 8'h80;
        mode       = 2'd0;
        tick();
        tick();
        check_cleared("reset");
        rst = 1'b0;
        tick();
        tick();
        check_cleared("idle after reset");

        for (int i = 0; i < 7; i++) begin
            string tag;
            tag  = $sformatf("vec%0d", i);
            mode = tv[i].mode;
            run_sweep(tag, tv[i].tbl, 1'b0);
            check({tag, " err_count"}, int'(err_count), tv[i].err);
            check({tag, " fail_valid"}, int'(fail_valid), tv[i].fv);
            if (tv[i].fv != 0) check({tag, " first_fail"}, int'(first_fail), tv[i].ff);
            check({tag, " pass"}, int'(pass), tv[i].pss);
        end

        // Results stay frozen in DONE while start is low, even if the gate changes.
        mode = 2'd2;
        repeat (3) tick();
        check("done hold done", int'(done), 1);
        check("done hold err_count", int'(err_count), 4);
        check("done hold first_fail", int'(first_fail), 0);
        check("done hold vec_out", int'(vec_out), 3);

        // Start held high across the sweep, then restart straight out of DONE.
        mode = 2'd1;
        run_sweep("held", 4'b1000, 1'b1);
        check("held err_count", int'(err_count), 1);
        check("held done", int'(done), 1);
        tick();
        start = 1'b0;
        check("restart busy", int'(busy), 1);
        check("restart done", int'(done), 0);
        check("restart err_count", int'(err_count), 0);
        check("restart fail_valid", int'(fail_valid), 0);
        check("restart vec_out", int'(vec_out), 0);
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        check("restart complete", int'(done), 1);

        // Reset at cycle 5 of a sweep that has already accumulated errors.
        mode      = 2'd2;
        exp_table = 4'b1000;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("pre-reset err_count", int'(err_count), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_cleared("mid-sweep reset");
        tick();
        tick();
        check_cleared("post-reset idle");
        mode = 2'd0;
        run_sweep("after reset", 4'b1000, 1'b0);
        check("after reset pass", int'(pass), 1);
        check("after reset err_count", int'(err_count), 0);

        // 3-input AND with SETTLE=3: 8 vectors * 4 cycles + 1.
        start3 = 1'b1;
        tick();
        start3  = 1'b0;
        lat     = 1;
        seq_bad = 0;
        while (!done3 && lat < 60) begin
            if (!busy3 || vec_out3 != 3'((lat - 1) / 4)) seq_bad++;
            tick();
            lat++;
        end
        check("and3 vec sequence", seq_bad, 0);
        check("and3 done latency", lat, 33);
        check("and3 pass", int'(pass3), 1);
        check("and3 err_count", int'(err_count3), 0);
        check("and3 fail_valid", int'(fail_valid3), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/gate_test_sequencer.md
GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

Interface
REQ-001 SHALL have parameter NUM_IN, default 2: number of gate inputs driven; legal 1..4.
REQ-002 SHALL have parameter SETTLE, default 1: cycles each vector is held before sampling; legal 1..255.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1: begins a sweep when sampled high in IDLE or DONE.
REQ-006 SHALL have port exp_table  input  2**NUM_IN: expected gate output, bit k for input vector k; sampled only in SAMPLE.
REQ-007 SHALL have port y_in  input  1: output of the gate under test.
REQ-008 SHALL have port vec_out  output  NUM_IN: registered input vector to the gate under test; bit 0 drives b, bit 1 drives a for a 2-input gate.
REQ-009 SHALL have port busy  output  1: high in SETTLE and SAMPLE.
REQ-010 SHALL have port done  output  1: high in DONE only.
REQ-011 SHALL have port pass  output  1: high in DONE when err_count is 0.
REQ-012 SHALL have port err_count  output  NUM_IN+1: number of mismatching vectors in the current or last sweep.
REQ-013 SHALL have port first_fail  output  NUM_IN: lowest vector index that mismatched.
REQ-014 SHALL have port fail_valid  output  1: high once first_fail holds a captured index.

Function
REQ-015 SHALL implement a 4-state FSM: IDLE, SETTLE, SAMPLE, DONE.
REQ-016 SHALL, in IDLE or DONE with start=1, load vec_out=0, settle counter=0, err_count=0 and fail_valid=0, and enter SETTLE next cycle.
REQ-017 SHALL, in IDLE or DONE with start=0, hold state and all outputs.
REQ-018 SHALL, in SETTLE, hold vec_out, increment the settle counter, and enter SAMPLE when the counter equals SETTLE-1.
REQ-019 SHALL, in SAMPLE, compare y_in with exp_table[vec_out] in that cycle.
REQ-020 SHALL, on a SAMPLE mismatch, add 1 to err_count, and load first_fail=vec_out with fail_valid=1 if fail_valid was 0.
REQ-021 SHALL, in SAMPLE with vec_out below 2**NUM_IN-1, load vec_out+1, clear the settle counter and return to SETTLE.
REQ-022 SHALL, in SAMPLE with vec_out equal to 2**NUM_IN-1, enter DONE and hold vec_out without wrapping.
REQ-023 SHALL ignore start while busy=1; a sweep is never restarted or extended mid-flight.
REQ-024 SHALL assert done exactly 2**NUM_IN*(SETTLE+1)+1 cycles after the edge that samples start; this is 9 cycles at the defaults.
REQ-025 SHALL never wrap err_count; its width holds the maximum of 2**NUM_IN.
REQ-026 SHALL hold done, pass, err_count, first_fail and fail_valid stable in DONE until start restarts the sweep.
REQ-027 SHALL make every output a direct register output or a pure decode of FSM state, with no combinational path from y_in or start.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, force IDLE, with vec_out, settle counter, err_count and first_fail at 0 and busy, done, pass and fail_valid at 0.
REQ-029 SHALL give rst priority over start and over any in-progress sweep; reset mid-sweep discards partial results.
REQ-030 SHALL, after rst deasserts, take no action until start is sampled high.

Verification
REQ-031 SHALL test a correct AND gate: y_in=&vec_out, exp_table=4'b1000, start pulse -> done at cycle 9, pass=1, err_count=0, fail_valid=0, vec_out sequence 0,0,1,1,2,2,3,3.
REQ-032 SHALL test a stuck-at-0 gate: y_in=0, exp_table=4'b1000 -> err_count=1, first_fail=3, fail_valid=1, pass=0.
REQ-033 SHALL test a gate mismatch: AND gate connected, exp_table=4'b1110 (OR) -> err_count=2, first_fail=1, pass=0.
REQ-034 SHALL test start held high for the whole sweep -> single sweep, done at cycle 9, then an immediate restart from DONE with err_count cleared to 0 on the next cycle.
REQ-035 SHALL test rst=1 at cycle 5 of a sweep -> next cycle IDLE, all outputs 0; a following start gives a full 9-cycle sweep with correct results.
REQ-036 SHALL test SETTLE=3 and NUM_IN=3 with a 3-input AND -> done at cycle 33, pass=1.
